if_prefetch: RTL and testbench

- Parametrised instruction-fetch front end for the 5-stage core; replaces the fixed pc_reg + if_id pair.
- Keeps its own PC and issues pipelined requests to instruction memory with a ready/valid handshake and several requests in flight.
- Buffers returned instructions with their PCs in a prefetch FIFO and presents them to ID through a valid/ready handshake.
- Handles branch/jump redirect by flushing the FIFO and discarding stale in-flight responses.

---
 rtl/if_prefetch_pkg.sv | 10 +
 rtl/inst_fifo.sv | 47 ++++
 rtl/if_prefetch.sv | 96 +++++++++
 tb/tb_if_prefetch.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_prefetch_pkg.sv
// Shared fetch-path widths and defaults used by the IF and ID stages.
package if_prefetch_pkg;

   localparam int unsigned INST_ADDR_BUS = 32;
   localparam int unsigned INST_BUS      = 32;
   localparam int unsigned INST_BYTES    = INST_BUS / 8;

   localparam logic [INST_ADDR_BUS-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/inst_fifo.sv
// Synchronous prefetch FIFO holding {pc, instruction} pairs; wrap-bit pointers.
module inst_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count   = wr_ptr - rd_ptr;
   assign head    = mem[rd_ptr[AW-1:0]];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: PC, pipelined memory requests, prefetch FIFO toward ID,
// and redirect handling that flushes the FIFO and drops stale in-flight responses.
module if_prefetch
   import if_prefetch_pkg::*;
#(
   parameter int unsigned     XLEN        = INST_ADDR_BUS,
   parameter int unsigned     DEPTH       = 4,
   parameter int unsigned     OUTSTANDING = 2,
   parameter logic [XLEN-1:0] RESET_PC    = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic            clk,
   input  logic            rst,
   output logic            mem_req_o,
   output logic [XLEN-1:0] mem_addr_o,
   input  logic            mem_ready_i,
   input  logic            mem_rvalid_i,
   input  logic [XLEN-1:0] mem_rdata_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            id_valid_o,
   input  logic            id_ready_i,
   output logic [XLEN-1:0] id_pc_o,
   output logic [XLEN-1:0] id_inst_o
);

   localparam int unsigned     CW      = $clog2(DEPTH) + 1;
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(INST_BYTES);

   logic [XLEN-1:0]   fetch_pc;
   logic [XLEN-1:0]   resp_pc;
   logic [CW-1:0]     in_flight;
   logic [CW-1:0]     discard;
   logic [CW-1:0]     live;
   logic [CW-1:0]     fifo_count;
   logic [CW:0]       occupancy;
   logic              accept;
   logic              push;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [2*XLEN-1:0] head;

   // Credit rule: FIFO entries plus live in-flight responses never exceed DEPTH,
   // so every live response is guaranteed a slot on arrival.
   assign live      = in_flight - discard;
   assign occupancy = {1'b0, fifo_count} + {1'b0, live};
   assign mem_req_o = !rst && !redirect_i
                      && (in_flight < CW'(OUTSTANDING))
                      && (occupancy < (CW+1)'(DEPTH));
   assign mem_addr_o = fetch_pc;
   assign accept     = mem_req_o && mem_ready_i;

   assign push = mem_rvalid_i && !redirect_i && (discard == '0) && !fifo_full;
   assign pop  = !fifo_empty && id_ready_i && !redirect_i;

   assign id_valid_o = !fifo_empty;
   assign id_pc_o    = fifo_empty ? '0 : head[2*XLEN-1:XLEN];
   assign id_inst_o  = fifo_empty ? '0 : head[XLEN-1:0];

   inst_fifo #(
      .WIDTH (2 * XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (redirect_i),
      .push      (push),
      .push_data ({resp_pc, mem_rdata_i}),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc  <= RESET_PC;
         resp_pc   <= RESET_PC;
         in_flight <= '0;
         discard   <= '0;
      end else if (redirect_i) begin
         // Everything still outstanding after this edge belongs to the old path.
         fetch_pc  <= redirect_pc_i;
         resp_pc   <= redirect_pc_i;
         in_flight <= in_flight - CW'(mem_rvalid_i);
         discard   <= in_flight - CW'(mem_rvalid_i);
      end else begin
         if (accept) fetch_pc <= fetch_pc + PC_STEP;
         if (push)   resp_pc  <= resp_pc + PC_STEP;
         in_flight <= in_flight + CW'(accept) - CW'(mem_rvalid_i);
         if (mem_rvalid_i && (discard != '0)) discard <= discard - CW'(1);
      end
   end

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: in-order memory model plus a PC-stream reference for the ID side.
module tb_if_prefetch;

   localparam int unsigned DEPTH       = 4;
   localparam int unsigned OUTSTANDING = 2;
   localparam logic [31:0] RESET_PC    = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ready_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        id_valid_o;
   logic        id_ready_i;
   logic [31:0] id_pc_o;
   logic [31:0] id_inst_o;

   if_prefetch #(
      .XLEN        (32),
      .DEPTH       (DEPTH),
      .OUTSTANDING (OUTSTANDING),
      .RESET_PC    (RESET_PC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .mem_req_o     (mem_req_o),
      .mem_addr_o    (mem_addr_o),
      .mem_ready_i   (mem_ready_i),
      .mem_rvalid_i  (mem_rvalid_i),
      .mem_rdata_i   (mem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .id_valid_o    (id_valid_o),
      .id_ready_i    (id_ready_i),
      .id_pc_o       (id_pc_o),
      .id_inst_o     (id_inst_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int unsigned due;
      bit          stale;
   } req_t;

   typedef struct {
      logic        id_ready;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
   } vec_t;

   int          tests  = 0;
   int          failed = 0;
   int unsigned cyc    = 0;
   int unsigned lat_lo = 1;
   int unsigned lat_hi = 1;

   req_t        q[$];
   int          occ;
   logic [31:0] exp_fetch;
   logic [31:0] exp_id_pc;
   logic [31:0] popped[$];
   logic [31:0] accepted[$];

   logic        s_rv, s_acc, s_pop;
   logic [31:0] s_addr, s_pop_pc;

   vec_t        vecs[10];

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC001_D00D;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drive the memory response, then compare outputs against the model mid-cycle.
   task automatic pre();
      int   live;
      logic exp_req;
      s_rv         = !rst && (q.size() > 0) && (q[0].due <= cyc);
      mem_rvalid_i = s_rv;
      mem_rdata_i  = s_rv ? inst_of(q[0].addr) : $urandom();
      #1;
      live = 0;
      foreach (q[i]) if (!q[i].stale) live++;
      exp_req = !rst && !redirect_i && (q.size() < OUTSTANDING) && ((occ + live) < DEPTH);
      check("mem_req", 32'(mem_req_o), 32'(exp_req));
      check("mem_addr", mem_addr_o, exp_fetch);
      check("id_valid", 32'(id_valid_o), 32'(occ != 0));
      if (!id_valid_o) begin
         check("id_pc_idle", id_pc_o, 32'h0);
         check("id_inst_idle", id_inst_o, 32'h0);
      end
      s_pop = (occ != 0) && id_ready_i && !redirect_i;
      if (s_pop) begin
         check("id_pc", id_pc_o, exp_id_pc);
         check("id_inst", id_inst_o, inst_of(exp_id_pc));
      end
      check("inv_in_flight", 32'(q.size() <= OUTSTANDING), 32'h1);
      check("inv_credit", 32'((occ + live) <= DEPTH), 32'h1);
      s_acc    = mem_req_o && mem_ready_i;
      s_addr   = mem_addr_o;
      s_pop_pc = id_pc_o;
   endtask

   task automatic post();
      req_t hd;
      @(posedge clk);
      if (rst) begin
         q.delete();
         occ       = 0;
         exp_fetch = RESET_PC;
         exp_id_pc = RESET_PC;
      end else begin
         if (s_rv) begin
            hd = q.pop_front();
            if (!redirect_i && !hd.stale) occ++;
         end
         if (s_pop) begin
            occ--;
            popped.push_back(s_pop_pc);
            exp_id_pc += 32'd4;
         end
         if (s_acc) begin
            q.push_back('{addr: s_addr, due: cyc + $urandom_range(lat_hi, lat_lo), stale: 1'b0});
            accepted.push_back(s_addr);
            exp_fetch += 32'd4;
         end
         if (redirect_i) begin
            foreach (q[i]) q[i].stale = 1'b1;
            occ       = 0;
            exp_fetch = redirect_pc_i;
            exp_id_pc = redirect_pc_i;
         end
      end
      cyc++;
      #1;
   endtask

   task automatic step();
      pre();
      post();
   endtask

   task automatic reset_dut();
      rst        = 1'b1;
      redirect_i = 1'b0;
      step();
      rst = 1'b0;
      popped.delete();
      accepted.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit found;

      vecs[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
      vecs[1] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
      vecs[2] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
      vecs[3] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
      vecs[4] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
      vecs[5] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
      vecs[6] = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
      vecs[7] = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h10};
      vecs[8] = '{1'b1, 1'b0, 32'h20, 1'b1, 32'h10};
      vecs[9] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14};

      rst           = 1'b1;
      redirect_i    = 1'b0;
      redirect_pc_i = '0;
      mem_ready_i   = 1'b1;
      mem_rvalid_i  = 1'b0;
      mem_rdata_i   = '0;
      id_ready_i    = 1'b1;
      occ           = 0;
      exp_fetch     = RESET_PC;
      exp_id_pc     = RESET_PC;
      @(posedge clk);
      #1;

      // Zero-wait memory fill, then a short ID stall that hits the credit limit.
      lat_lo = 1; lat_hi = 1;
      reset_dut();
      for (int unsigned k = 0; k < 10; k++) begin
         id_ready_i = vecs[k].id_ready;
         pre();
         check($sformatf("vec%0d_req", k), 32'(mem_req_o), 32'(vecs[k].exp_req));
         check($sformatf("vec%0d_addr", k), mem_addr_o, vecs[k].exp_addr);
         check($sformatf("vec%0d_valid", k), 32'(id_valid_o), 32'(vecs[k].exp_valid));
         if (vecs[k].exp_valid) check($sformatf("vec%0d_pc", k), id_pc_o, vecs[k].exp_pc);
         post();
      end

      // Backpressure: ID stalled for 20 cycles fills exactly DEPTH entries.
      reset_dut();
      id_ready_i = 1'b0;
      for (int i = 0; i < 20; i++) step();
      pre();
      check("bp_req_low", 32'(mem_req_o), 32'h0);
      check("bp_addr", mem_addr_o, 32'h10);
      check("bp_head", id_pc_o, 32'h0);
      post();
      popped.delete();
      accepted.delete();
      id_ready_i = 1'b1;
      for (int i = 0; i < 12; i++) step();
      for (int i = 0; i < 4; i++) check($sformatf("bp_pop%0d", i), popped[i], 32'(4 * i));
      check("bp_resume", accepted[0], 32'h10);

      // Redirect with 0x10 and 0x14 in flight.
      lat_lo = 3; lat_hi = 3;
      reset_dut();
      found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         if (q.size() == 2 && q[1].addr == 32'h14) found = 1;
         else step();
      end
      check("rd1_found", 32'(found), 32'h1);
      redirect_i = 1'b1; redirect_pc_i = 32'h100;
      step();
      redirect_i = 1'b0;
      popped.delete();
      pre();
      check("rd1_empty", 32'(id_valid_o), 32'h0);
      check("rd1_addr", mem_addr_o, 32'h100);
      post();
      for (int i = 0; i < 40 && popped.size() == 0; i++) step();
      check("rd1_first_pc", (popped.size() > 0) ? popped[0] : 32'hDEAD_BEEF, 32'h100);

      // Redirect in the same cycle as the response for 0x8, with 0xC still in flight.
      lat_lo = 2; lat_hi = 2;
      reset_dut();
      found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         if (q.size() == 2 && q[0].addr == 32'h8 && q[0].due <= cyc) found = 1;
         else step();
      end
      check("rd2_found", 32'(found), 32'h1);
      popped.delete();
      redirect_i = 1'b1; redirect_pc_i = 32'h200;
      step();
      redirect_i = 1'b0;
      for (int i = 0; i < 40 && popped.size() == 0; i++) step();
      check("rd2_first_pc", (popped.size() > 0) ? popped[0] : 32'hDEAD_BEEF, 32'h200);

      // Toggling mem_ready with 3-cycle latency.
      lat_lo = 3; lat_hi = 3;
      reset_dut();
      for (int i = 0; i < 60; i++) begin
         mem_ready_i = cyc[0];
         step();
      end
      check("tog_progress", 32'(popped.size() > 8), 32'h1);
      mem_ready_i = 1'b1;

      // Reset with three entries buffered.
      lat_lo = 1; lat_hi = 1;
      reset_dut();
      id_ready_i = 1'b0;
      for (int i = 0; i < 20 && occ != 3; i++) step();
      check("rst_fill3", 32'(occ), 32'h3);
      rst = 1'b1;
      step();
      pre();
      check("rst_valid", 32'(id_valid_o), 32'h0);
      check("rst_req", 32'(mem_req_o), 32'h0);
      post();
      rst = 1'b0;
      pre();
      check("rst_first_req", 32'(mem_req_o), 32'h1);
      check("rst_first_addr", mem_addr_o, RESET_PC);
      post();

      // Randomized traffic with redirects (including near address wrap) and resets.
      reset_dut();
      for (int i = 0; i < 4000; i++) begin
         int unsigned r;
         if (i % 500 == 0) begin
            lat_lo = 1;
            lat_hi = $urandom_range(4, 1);
         end
         r             = $urandom_range(299, 0);
         rst           = (r == 0);
         redirect_i    = (r >= 1) && (r < 10);
         redirect_pc_i = (r == 1) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
         mem_ready_i   = ($urandom_range(3, 0) != 0);
         id_ready_i    = ($urandom_range(3, 0) != 0);
         step();
      end
      rst        = 1'b0;
      redirect_i = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
